// File: rtl/aux_pkg.sv
// Shared types and constants for the HDMI aux (data-island) FIFO writer.
// Header/data word layout and the writer state encoding live here.
package aux_pkg;

    localparam int BURST_LEN = 32;
    localparam int HW        = 12;
    localparam int DW        = 12;
    localparam int FW        = 24;
    localparam int IDX_W     = $clog2(BURST_LEN);
    localparam int POS_MSB   = 23;
    localparam int POS_LSB   = 12;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        PAD,
        DROP
    } aux_state_e;

    function automatic logic [FW-1:0] header_word(
        input logic [HW-1:0] hcnt,
        input logic [HW-1:0] vcnt
    );
        logic [FW-1:0] w;
        w                  = '0;
        w[POS_MSB:POS_LSB] = hcnt;
        w[POS_LSB-1:0]     = vcnt;
        return w;
    endfunction

    function automatic logic [FW-1:0] data_word(
        input logic [IDX_W-1:0] idx,
        input logic [DW-1:0]    data
    );
        logic [FW-1:0] w;
        w                    = '0;
        w[POS_LSB +: IDX_W]  = idx;
        w[DW-1:0]            = data;
        return w;
    endfunction

endpackage

// File: rtl/edge_sync_reg.sv
// Input register stage for the source timing signals plus ADE/VDE edge
// detectors; shared with the receiver-side ADE generator.
module edge_sync_reg
    import aux_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ade_i,
    input  logic          vde_i,
    input  logic [HW-1:0] hcnt_i,
    input  logic [HW-1:0] vcnt_i,
    input  logic [DW-1:0] aux_data_i,
    output logic          ade_r_o,
    output logic          ade_rise_o,
    output logic          ade_fall_o,
    output logic          vde_rise_o,
    output logic [HW-1:0] hcnt_r_o,
    output logic [HW-1:0] vcnt_r_o,
    output logic [DW-1:0] aux_data_d_o
);

    logic          ade_r_q;
    logic          ade_q;
    logic          vde_r_q;
    logic          vde_q;
    logic [HW-1:0] hcnt_r_q;
    logic [HW-1:0] vcnt_r_q;
    logic [DW-1:0] aux_r_q;
    logic [DW-1:0] aux_d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ade_r_q  <= 1'b0;
            ade_q    <= 1'b0;
            vde_r_q  <= 1'b0;
            vde_q    <= 1'b0;
            hcnt_r_q <= '0;
            vcnt_r_q <= '0;
            aux_r_q  <= '0;
            aux_d_q  <= '0;
        end else begin
            ade_r_q  <= ade_i;
            ade_q    <= ade_r_q;
            vde_r_q  <= vde_i;
            vde_q    <= vde_r_q;
            hcnt_r_q <= hcnt_i;
            vcnt_r_q <= vcnt_i;
            aux_r_q  <= aux_data_i;
            aux_d_q  <= aux_r_q;
        end
    end

    assign ade_r_o      = ade_r_q;
    assign ade_rise_o   = ade_r_q & ~ade_q;
    assign ade_fall_o   = ~ade_r_q & ade_q;
    assign vde_rise_o   = vde_r_q & ~vde_q;
    assign hcnt_r_o     = hcnt_r_q;
    assign vcnt_r_o     = vcnt_r_q;
    // Delayed one extra cycle so data[0] follows the header back-to-back.
    assign aux_data_d_o = aux_d_q;

endmodule

// File: rtl/aux_fifo_writer.sv
// Packs each source ADE window into one header plus BURST_LEN data words
// for the aux send FIFO, and counts bursts per line for the transmitter.
module aux_fifo_writer
    import aux_pkg::*;
(
    input  logic          fifo_clk,
    input  logic          sys_rst_n,
    input  logic          ade,
    input  logic          vde,
    input  logic [HW-1:0] hcnt,
    input  logic [HW-1:0] vcnt,
    input  logic [DW-1:0] aux_data,
    input  logic          fifo_afull,
    input  logic          fifo_full,
    output logic [FW-1:0] fifo_din,
    output logic          fifo_wr_en,
    output logic [3:0]    ade_num,
    output logic [7:0]    drop_cnt,
    output logic          err_len,
    output logic          err_ovf
);

    logic          ade_r;
    logic          ade_rise;
    logic          ade_fall;
    logic          vde_rise;
    logic [HW-1:0] hcnt_r;
    logic [HW-1:0] vcnt_r;
    logic [DW-1:0] aux_data_d;

    edge_sync_reg u_sync (
        .clk          (fifo_clk),
        .rst_n        (sys_rst_n),
        .ade_i        (ade),
        .vde_i        (vde),
        .hcnt_i       (hcnt),
        .vcnt_i       (vcnt),
        .aux_data_i   (aux_data),
        .ade_r_o      (ade_r),
        .ade_rise_o   (ade_rise),
        .ade_fall_o   (ade_fall),
        .vde_rise_o   (vde_rise),
        .hcnt_r_o     (hcnt_r),
        .vcnt_r_o     (vcnt_r),
        .aux_data_d_o (aux_data_d)
    );

    aux_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic [FW-1:0]    din_q, din_d;
    logic             wr_en_q, wr_en_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       num_q, num_d;
    logic [7:0]       drop_q, drop_d;
    logic             err_len_q, err_len_d;
    logic             err_ovf_q, err_ovf_d;

    logic             start;
    logic             drop_hit;
    logic             len_bad;

    always_ff @(posedge fifo_clk) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            din_q     <= '0;
            wr_en_q   <= 1'b0;
            cnt_q     <= '0;
            num_q     <= '0;
            drop_q    <= '0;
            err_len_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            din_q     <= din_d;
            wr_en_q   <= wr_en_d;
            cnt_q     <= cnt_d;
            num_q     <= num_d;
            drop_q    <= drop_d;
            err_len_q <= err_len_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        din_d    = din_q;
        wr_en_d  = 1'b0;
        start    = 1'b0;
        drop_hit = 1'b0;
        len_bad  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ade_rise) begin
                    if (!fifo_afull) begin
                        wr_en_d = 1'b1;
                        din_d   = header_word(hcnt_r, vcnt_r);
                        idx_d   = '0;
                        start   = 1'b1;
                        state_d = BURST;
                    end else begin
                        drop_hit = 1'b1;
                        state_d  = DROP;
                    end
                end
            end
            BURST: begin
                wr_en_d = 1'b1;
                din_d   = data_word(idx_q, aux_data_d);
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    // ade still high: the source window overran the burst
                    len_bad = ade_r;
                    state_d = IDLE;
                end else if (ade_fall) begin
                    len_bad = 1'b1;
                    state_d = PAD;
                end
            end
            PAD: begin
                wr_en_d = 1'b1;
                din_d   = data_word(idx_q, '0);
                idx_d   = idx_q + 1'b1;
                pend_d  = pend_q | ade_rise;
                drop_hit = ade_rise;
                if (idx_q == IDX_LAST) begin
                    pend_d  = 1'b0;
                    state_d = (pend_q | ade_rise) ? DROP : IDLE;
                end
            end
            DROP: begin
                if (!ade_r) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        drop_d    = drop_q;
        err_len_d = err_len_q | len_bad;
        err_ovf_d = err_ovf_q | (wr_en_q & fifo_full);
        cnt_d     = cnt_q;
        num_d     = num_q;
        if (drop_hit && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
        if (start && cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (vde_rise) begin
            num_d = cnt_q;
            cnt_d = start ? 4'd1 : 4'd0;
        end
    end

    assign fifo_din   = din_q;
    assign fifo_wr_en = wr_en_q;
    assign ade_num    = num_q;
    assign drop_cnt   = drop_q;
    assign err_len    = err_len_q;
    assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_aux_fifo_writer.sv
// Directed and randomized bench for aux_fifo_writer with a burst-level
// reference model of header/data/pad framing, drops and line counts.
module tb_aux_fifo_writer;

    logic        fifo_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        ade = 1'b0;
    logic        vde = 1'b0;
    logic [11:0] hcnt = '0;
    logic [11:0] vcnt = '0;
    logic [11:0] aux_data = '0;
    logic        fifo_afull = 1'b0;
    logic        fifo_full = 1'b0;
    logic [23:0] fifo_din;
    logic        fifo_wr_en;
    logic [3:0]  ade_num;
    logic [7:0]  drop_cnt;
    logic        err_len;
    logic        err_ovf;

    aux_fifo_writer dut (
        .fifo_clk   (fifo_clk),
        .sys_rst_n  (sys_rst_n),
        .ade        (ade),
        .vde        (vde),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .aux_data   (aux_data),
        .fifo_afull (fifo_afull),
        .fifo_full  (fifo_full),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .ade_num    (ade_num),
        .drop_cnt   (drop_cnt),
        .err_len    (err_len),
        .err_ovf    (err_ovf)
    );

    always #5 fifo_clk = ~fifo_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [23:0] wq[$];
    int          wc[$];

    // model state
    int drop_m = 0;
    bit elen_m = 0;
    bit ovf_m = 0;
    int started = 0;

    always @(posedge fifo_clk) cyc <= cyc + 1;

    always @(negedge fifo_clk) begin
        if (fifo_wr_en) begin
            wq.push_back(fifo_din);
            wc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fifo_clk);
        #1;
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_err_len"}, 32'(err_len), 32'(elen_m));
        chk({tag, "_err_ovf"}, 32'(err_ovf), 32'(ovf_m));
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(drop_m));
    endtask

    // Compare captured writes against header + data[0..len-1] + zero pad.
    task automatic chk_burst(input string tag, input logic [11:0] h0,
                             input logic [11:0] v0, input int len,
                             input logic [11:0] d[$], input int dc);
        int n;
        logic [23:0] exp;
        n = wq.size();
        chk({tag, "_nwr"}, 32'(n), 33);
        if (n == 33) begin
            chk({tag, "_hdr"}, 32'(wq[0]), 32'((32'(h0) << 12) | 32'(v0)));
            chk({tag, "_lat"}, 32'(wc[0]), 32'(dc + 2));
            chk({tag, "_cont"}, 32'(wc[32] - wc[0]), 32);
            for (int i = 0; i < 32; i++) begin
                exp = 24'((i << 12) | ((i < len) ? int'(d[i]) : 0));
                chk({tag, "_word"}, 32'(wq[i+1]), 32'(exp));
            end
        end
    endtask

    task automatic burst(input string tag, input int len, input bit afull,
                         input bit full, input bit directed);
        logic [11:0] d[$];
        logic [11:0] h0;
        logic [11:0] v0;
        int dc;
        h0 = directed ? 12'd1 : 12'($urandom);
        v0 = directed ? 12'd5 : 12'($urandom);
        for (int i = 0; i < len; i++) begin
            d.push_back(directed ? 12'(12'h100 + i) : 12'($urandom));
        end
        wq.delete();
        wc.delete();
        dc = cyc;
        for (int i = 0; i < len; i++) begin
            ade        = 1'b1;
            hcnt       = 12'(h0 + i);
            vcnt       = v0;
            aux_data   = d[i];
            fifo_afull = afull;
            fifo_full  = full;
            tick();
        end
        ade = 1'b0;
        aux_data = 12'($urandom);
        repeat (40) tick();
        fifo_afull = 1'b0;
        fifo_full  = 1'b0;
        tick();
        if (afull) begin
            drop_m = (drop_m < 255) ? drop_m + 1 : 255;
            chk({tag, "_drop_nwr"}, 32'(wq.size()), 0);
        end else begin
            started++;
            if (len != 32) elen_m = 1;
            if (full) ovf_m = 1;
            chk_burst(tag, h0, v0, len, d, dc);
        end
        chk_flags(tag);
    endtask

    task automatic vde_pulse(input string tag);
        int exp;
        exp = (started > 15) ? 15 : started;
        started = 0;
        vde = 1'b1;
        repeat (4) tick();
        chk({tag, "_ade_num"}, 32'(ade_num), 32'(exp));
        vde = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        logic [11:0] d[$];
        int dc;
        int len;
        bit af;

        repeat (3) tick();
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_din", 32'(fifo_din), 0);
        chk("rst_ade_num", 32'(ade_num), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_err_len", 32'(err_len), 0);
        chk("rst_err_ovf", 32'(err_ovf), 0);
        sys_rst_n = 1'b1;
        repeat (3) tick();

        burst("b32", 32, 1'b0, 1'b0, 1'b1);
        chk("b32_hdr_const", 32'(wq[0]), 32'h001005);
        burst("b20", 20, 1'b0, 1'b0, 1'b0);
        burst("b40", 40, 1'b0, 1'b0, 1'b0);
        burst("afull", 32, 1'b1, 1'b0, 1'b0);
        burst("after_drop", 32, 1'b0, 1'b0, 1'b0);

        // second ADE arriving while the first is still padding
        wq.delete();
        wc.delete();
        d.delete();
        dc = cyc;
        for (int i = 0; i < 5; i++) begin
            d.push_back(12'($urandom));
            ade = 1'b1; hcnt = 12'(100 + i); vcnt = 12'd7; aux_data = d[i];
            tick();
        end
        ade = 1'b0;
        repeat (3) tick();
        ade = 1'b1;
        repeat (5) tick();
        ade = 1'b0;
        repeat (40) tick();
        started++;
        elen_m = 1;
        drop_m++;
        chk_burst("paddrop", 12'd100, 12'd7, 5, d, dc);
        chk_flags("paddrop");

        vde_pulse("line0");
        for (int b = 0; b < 10; b++) begin
            burst("line10", int'($urandom_range(1, 32)), 1'b0, 1'b0, 1'b0);
        end
        vde_pulse("line10");
        vde_pulse("line_empty");
        for (int b = 0; b < 17; b++) begin
            burst("line17", int'($urandom_range(1, 36)), 1'b0, 1'b0, 1'b0);
        end
        vde_pulse("line_sat");

        for (int b = 0; b < 8; b++) begin
            len = int'($urandom_range(1, 40));
            af = ($urandom_range(0, 3) == 0);
            burst("rand", len, af, 1'b0, 1'b0);
        end
        vde_pulse("line_rand");

        burst("ovf", 32, 1'b0, 1'b1, 1'b0);

        // drop counter saturation with short ADE pulses
        wq.delete();
        fifo_afull = 1'b1;
        for (int i = 0; i < 260; i++) begin
            ade = 1'b1;
            tick();
            ade = 1'b0;
            repeat (2) tick();
            drop_m = (drop_m < 255) ? drop_m + 1 : 255;
        end
        repeat (3) tick();
        fifo_afull = 1'b0;
        chk("sat_nwr", 32'(wq.size()), 0);
        chk_flags("sat");

        // reset while data word 15 is on the FIFO port
        wq.delete();
        wc.delete();
        for (int i = 0; i < 18; i++) begin
            ade = 1'b1; hcnt = 12'(i); vcnt = 12'd9; aux_data = 12'($urandom);
            tick();
        end
        sys_rst_n = 1'b0;
        tick();
        chk("mrst_wr_en", 32'(fifo_wr_en), 0);
        chk("mrst_din", 32'(fifo_din), 0);
        chk("mrst_ade_num", 32'(ade_num), 0);
        chk("mrst_drop", 32'(drop_cnt), 0);
        chk("mrst_err_len", 32'(err_len), 0);
        chk("mrst_err_ovf", 32'(err_ovf), 0);
        chk("mrst_nwr", 32'(wq.size()), 17);
        repeat (5) tick();
        ade = 1'b0;
        repeat (3) tick();
        chk("mrst_hold_wr", 32'(wq.size()), 17);
        sys_rst_n = 1'b1;
        drop_m = 0; elen_m = 0; ovf_m = 0; started = 0;
        repeat (3) tick();
        burst("post_rst", 32, 1'b0, 1'b0, 1'b0);
        vde_pulse("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
